// File: rtl/gpio_port_bank.sv
`default_nettype none
// ============================================================================
// Module   : gpio_port_bank
// Purpose  : Multi-port GPIO peripheral for the SoC peripheral bus.
//            NUM_PORTS ports of PORT_WIDTH pins each. Every port has:
//              - direction and output registers;
//              - atomic set/clear/toggle writes;
//              - synchronised input readback;
//              - per-pin rising/falling edge interrupts with W1C status.
// Ports    : clk, rst      - single clock, synchronous active-high reset
//            bus_addr      - byte address (bits [1:0] ignored)
//            bus_wdata     - write data (low PORT_WIDTH bits used)
//            bus_we/bus_re - one-cycle write / read strobes
//            bus_rdata     - read data, zero-extended, held until next read
//            bus_rvalid    - one-cycle pulse, bus_rdata valid
//            gpio_pin_in   - asynchronous pad inputs
//            gpio_pin_out  - output register values
//            gpio_pin_dir  - output enables (1 = drive)
//            irq           - registered OR of all status bits
// Revision : 1.0 - initial release
// ============================================================================
module gpio_port_bank #(
    parameter int NUM_PORTS   = 2,
    parameter int PORT_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           bus_addr,
    input  logic [31:0]                     bus_wdata,
    input  logic                            bus_we,
    input  logic                            bus_re,
    output logic [31:0]                     bus_rdata,
    output logic                            bus_rvalid,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_pin_in,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_pin_out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_pin_dir,
    output logic                            irq
);

    localparam int c_NPIN = NUM_PORTS * PORT_WIDTH;

    // Word offsets within a port's 0x40-byte window (bus_addr[5:2]).
    localparam logic [3:0] c_OFS_DIR     = 4'h0;
    localparam logic [3:0] c_OFS_OUT     = 4'h1;
    localparam logic [3:0] c_OFS_IN      = 4'h2;
    localparam logic [3:0] c_OFS_SET     = 4'h3;
    localparam logic [3:0] c_OFS_CLR     = 4'h4;
    localparam logic [3:0] c_OFS_TGL     = 4'h5;
    localparam logic [3:0] c_OFS_RISE_EN = 4'h6;
    localparam logic [3:0] c_OFS_FALL_EN = 4'h7;
    localparam logic [3:0] c_OFS_STATUS  = 4'h8;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [3:0]            w_ofs;
    logic [31:0]           w_idx_ext;
    logic [PORT_WIDTH-1:0] w_wd;

    assign w_ofs = bus_addr[5:2];
    assign w_wd  = bus_wdata[PORT_WIDTH-1:0];

    // Port index widened to 32 bits so it can be compared against any port
    // number; a bus with no bits above the port window only addresses port 0.
    generate
        if (ADDR_WIDTH > 6) begin : g_idx
            assign w_idx_ext = 32'(bus_addr[ADDR_WIDTH-1:6]);
        end else begin : g_no_idx
            assign w_idx_ext = '0;
        end
    endgenerate

    // Byte-lane bits and upper write-data bits carry no meaning here.
    logic w_unused;
    assign w_unused = &{1'b0, bus_addr[1:0], bus_wdata};

    // ------------------------------------------------------------------
    // Input synchroniser and edge detection
    // ------------------------------------------------------------------
    logic [c_NPIN-1:0] r_sync [SYNC_STAGES];
    logic [c_NPIN-1:0] r_prev;
    logic [c_NPIN-1:0] w_in;
    logic [c_NPIN-1:0] w_rise;
    logic [c_NPIN-1:0] w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= gpio_pin_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_in   = r_sync[SYNC_STAGES-1];
    assign w_rise = w_in & ~r_prev;
    assign w_fall = ~w_in & r_prev;

    // ------------------------------------------------------------------
    // Per-port register file
    // ------------------------------------------------------------------
    logic [c_NPIN-1:0] w_dir_flat;
    logic [c_NPIN-1:0] w_out_flat;
    logic [c_NPIN-1:0] w_rise_en_flat;
    logic [c_NPIN-1:0] w_fall_en_flat;
    logic [c_NPIN-1:0] w_status_flat;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            logic [PORT_WIDTH-1:0] r_dir;
            logic [PORT_WIDTH-1:0] r_out;
            logic [PORT_WIDTH-1:0] r_rise_en;
            logic [PORT_WIDTH-1:0] r_fall_en;
            logic [PORT_WIDTH-1:0] r_status;
            logic                  w_wr;
            logic [PORT_WIDTH-1:0] w_evt;
            logic [PORT_WIDTH-1:0] w_w1c;

            assign w_wr  = bus_we && (w_idx_ext == 32'(p));
            assign w_evt = (w_rise[p*PORT_WIDTH +: PORT_WIDTH] & r_rise_en)
                         | (w_fall[p*PORT_WIDTH +: PORT_WIDTH] & r_fall_en);
            assign w_w1c = (w_wr && (w_ofs == c_OFS_STATUS)) ? w_wd : '0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dir     <= '0;
                    r_out     <= '0;
                    r_rise_en <= '0;
                    r_fall_en <= '0;
                    r_status  <= '0;
                end else begin
                    if (w_wr) begin
                        case (w_ofs)
                            c_OFS_DIR:     r_dir     <= w_wd;
                            c_OFS_OUT:     r_out     <= w_wd;
                            c_OFS_SET:     r_out     <= r_out | w_wd;
                            c_OFS_CLR:     r_out     <= r_out & ~w_wd;
                            c_OFS_TGL:     r_out     <= r_out ^ w_wd;
                            c_OFS_RISE_EN: r_rise_en <= w_wd;
                            c_OFS_FALL_EN: r_fall_en <= w_wd;
                            default:       ;
                        endcase
                    end
                    // New events are OR-ed in after the clear so a same-cycle
                    // event keeps its bit set.
                    r_status <= (r_status & ~w_w1c) | w_evt;
                end
            end

            assign w_dir_flat[p*PORT_WIDTH +: PORT_WIDTH]     = r_dir;
            assign w_out_flat[p*PORT_WIDTH +: PORT_WIDTH]     = r_out;
            assign w_rise_en_flat[p*PORT_WIDTH +: PORT_WIDTH] = r_rise_en;
            assign w_fall_en_flat[p*PORT_WIDTH +: PORT_WIDTH] = r_fall_en;
            assign w_status_flat[p*PORT_WIDTH +: PORT_WIDTH]  = r_status;
        end
    endgenerate

    assign gpio_pin_out = w_out_flat;
    assign gpio_pin_dir = w_dir_flat;

    // ------------------------------------------------------------------
    // Read path: muxes the pre-edge register values, so a same-cycle
    // write to the read address returns the old contents.
    // ------------------------------------------------------------------
    logic [PORT_WIDTH-1:0] w_rd_val;
    logic [31:0]           w_rd_word;

    always_comb begin
        w_rd_val = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_idx_ext == 32'(p)) begin
                case (w_ofs)
                    c_OFS_DIR:     w_rd_val = w_dir_flat[p*PORT_WIDTH +: PORT_WIDTH];
                    c_OFS_OUT:     w_rd_val = w_out_flat[p*PORT_WIDTH +: PORT_WIDTH];
                    c_OFS_IN:      w_rd_val = w_in[p*PORT_WIDTH +: PORT_WIDTH];
                    c_OFS_RISE_EN: w_rd_val = w_rise_en_flat[p*PORT_WIDTH +: PORT_WIDTH];
                    c_OFS_FALL_EN: w_rd_val = w_fall_en_flat[p*PORT_WIDTH +: PORT_WIDTH];
                    c_OFS_STATUS:  w_rd_val = w_status_flat[p*PORT_WIDTH +: PORT_WIDTH];
                    default:       w_rd_val = '0;
                endcase
            end
        end
    end

    always_comb begin
        w_rd_word                 = '0;
        w_rd_word[PORT_WIDTH-1:0] = w_rd_val;
    end

    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_rvalid <= bus_re;
            if (bus_re) begin
                r_rdata <= w_rd_word;
            end
            r_irq <= |w_status_flat;
        end
    end

    assign bus_rdata  = r_rdata;
    assign bus_rvalid = r_rvalid;
    assign irq        = r_irq;

endmodule
`default_nettype wire
